// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM to MEM/WB register plus a req/ack data-memory handshake FSM.
// Optional access timeout is built when MEM_STAGE_TIMEOUT_EN is defined.
module mem_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validM_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic                  RegWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  input  logic                  dm_ack_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  output logic                  StallM_o,
  output logic [DATA_WIDTH-1:0] WBResultW_o,
  output logic [DATA_WIDTH-1:0] memData_r_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  MemToRegW_o,
  output logic                  err_o
);

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } state_e;

  state_e state_q, state_d;

  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [REG_WIDTH-1:0]  write_reg_q, write_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;

  logic memop;
  logic stall;
  logic timeout;

  // A request with both read and write set is treated as a write.
  assign memop = validM_i & (MemReadM_i | MemWriteM_i);

  // Upper result bits are only a memory address source below ADDR_WIDTH.
  if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUResultM_i[DATA_WIDTH-1:ADDR_WIDTH];
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Fires on the 16th consecutive ACCESS cycle without an ack.
  assign timeout = (state_q == StAccess) && !dm_ack_i && (cnt_q == 4'hF);

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == StAccess && !dm_ack_i) begin
      if (timeout) begin
        cnt_d = 4'h0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'h1;
      end
    end else begin
      cnt_d = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'h0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wb_result_d  = wb_result_q;
    mem_data_d   = mem_data_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    // Bubble by default: only the write enable is cleared, the rest holds.
    reg_write_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (memop) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWriteM_i;
          addr_d  = ALUResultM_i[ADDR_WIDTH-1:0];
          wdata_d = WriteDataM_i;
          state_d = StAccess;
        end else if (validM_i) begin
          wb_result_d  = ALUResultM_i;
          write_reg_d  = WriteRegM_i;
          reg_write_d  = RegWriteM_i;
          mem_to_reg_d = MemToRegM_i;
        end
      end
      StAccess: begin
        if (dm_ack_i) begin
          wb_result_d  = ALUResultM_i;
          write_reg_d  = WriteRegM_i;
          reg_write_d  = RegWriteM_i;
          mem_to_reg_d = MemToRegM_i;
          if (!we_q) begin
            mem_data_d = dm_rdata_i;
          end
          req_d   = 1'b0;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (timeout) begin
            req_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wb_result_q  <= '0;
      mem_data_q   <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wb_result_q  <= wb_result_d;
      mem_data_q   <= mem_data_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign StallM_o    = rst & stall;
  assign dm_req_o    = req_q;
  assign dm_we_o     = we_q;
  assign dm_addr_o   = addr_q;
  assign dm_wdata_o  = wdata_q;
  assign WBResultW_o = wb_result_q;
  assign memData_r_o = mem_data_q;
  assign WriteRegW_o = write_reg_q;
  assign RegWriteW_o = reg_write_q;
  assign MemToRegW_o = mem_to_reg_q;

endmodule
